// File: rtl/exception_ctrl_pkg.sv
// Shared constants, CP0 register addresses, FSM state type and exception
// priority encoder for the exception controller.
package exception_ctrl_pkg;

   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_RI      = 32'h0000_000a;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;

   localparam logic [31:0] EXC_VECTOR  = 32'h0000_0020;

   localparam logic [4:0]  CP0_STATUS  = 5'd12;
   localparam logic [4:0]  CP0_CAUSE   = 5'd13;
   localparam logic [4:0]  CP0_EPC     = 5'd14;

   // Bit positions inside the {eret, syscall, trap, ov, ri} flag vector
   localparam int FLAG_RI      = 0;
   localparam int FLAG_OV      = 1;
   localparam int FLAG_TRAP    = 2;
   localparam int FLAG_SYSCALL = 3;
   localparam int FLAG_ERET    = 4;

   typedef enum logic {
      ST_IDLE,
      ST_REDIRECT
   } state_t;

   function automatic logic [31:0] exc_priority(input logic       int_pending,
                                                input logic [4:0] flags);
      logic [31:0] code;
      code = EXC_NONE;
      if (int_pending)              code = EXC_INT;
      else if (flags[FLAG_RI])      code = EXC_RI;
      else if (flags[FLAG_OV])      code = EXC_OV;
      else if (flags[FLAG_TRAP])    code = EXC_TRAP;
      else if (flags[FLAG_SYSCALL]) code = EXC_SYSCALL;
      else if (flags[FLAG_ERET])    code = EXC_ERET;
      return code;
   endfunction

endpackage

// File: rtl/int_sync.sv
// Interrupt line conditioning. With INT_SYNC_EN defined the lines pass through
// a 2-flop synchronizer; otherwise they are a combinational pass-through.
module int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

`ifdef INT_SYNC_EN
   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg[gi] <= 1'b0;
               sync_reg[gi] <= 1'b0;
            end else begin
               meta_reg[gi] <= d[gi];
               sync_reg[gi] <= meta_reg[gi];
            end
         end
      end
   endgenerate

   assign q = sync_reg;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
   assign q = d;
`endif

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: CP0 forwarding, priority encoding, flush and
// fetch-redirect handshake. Optional INT_SYNC_EN synchronizes the interrupt lines.
module exception_ctrl
   import exception_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid_i,
   input  logic [4:0]  mem_exc_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic        mem_cp0_we_i,
   input  logic [4:0]  mem_cp0_waddr_i,
   input  logic [31:0] mem_cp0_wdata_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic [5:0]  int_i,
   output logic [5:0]  int_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] exc_pc_o,
   output logic        exc_in_delayslot_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready_i,
   output logic        stall_o
);

   state_t      state_reg, state_next;
   logic [31:0] redirect_pc_reg, redirect_pc_next;
   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_pending;
   logic [31:0] exc_code;

   int_sync #(.WIDTH(6)) u_int_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (int_i),
      .q     (int_o)
   );

   // Only the software-writable cause fields (IP1:0, IV, WP) are forwarded
   always_comb begin
      status_eff = cp0_status_i;
      cause_eff  = cp0_cause_i;
      epc_eff    = cp0_epc_i;
      if (mem_cp0_we_i) begin
         if (mem_cp0_waddr_i == CP0_STATUS) status_eff = mem_cp0_wdata_i;
         if (mem_cp0_waddr_i == CP0_EPC)    epc_eff    = mem_cp0_wdata_i;
         if (mem_cp0_waddr_i == CP0_CAUSE) begin
            cause_eff[9:8] = mem_cp0_wdata_i[9:8];
            cause_eff[22]  = mem_cp0_wdata_i[22];
            cause_eff[23]  = mem_cp0_wdata_i[23];
         end
      end
   end

   logic unused_cp0_bits;
   assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                              cause_eff[31:16], cause_eff[7:0]};

   assign int_pending = mem_valid_i && status_eff[0] && !status_eff[1] &&
                        ((status_eff[15:8] & cause_eff[15:8]) != 8'h00);

   // rst_n gating keeps the combinational commit path quiet during reset
   assign exc_code = (rst_n && mem_valid_i) ? exc_priority(int_pending, mem_exc_i)
                                            : EXC_NONE;

   assign exc_pc_o           = mem_pc_i;
   assign exc_in_delayslot_o = mem_in_delayslot_i;
   assign redirect_pc_o      = redirect_pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         redirect_pc_reg <= 32'h0;
      end else begin
         state_reg       <= state_next;
         redirect_pc_reg <= redirect_pc_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      redirect_pc_next = redirect_pc_reg;
      excepttype_o     = EXC_NONE;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      stall_o          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (exc_code != EXC_NONE) begin
               excepttype_o     = exc_code;
               flush_o          = 1'b1;
               state_next       = ST_REDIRECT;
               redirect_pc_next = (exc_code == EXC_ERET) ? epc_eff : EXC_VECTOR;
            end
         end
         ST_REDIRECT: begin
            redirect_valid_o = 1'b1;
            stall_o          = 1'b1;
            if (redirect_ready_i) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus a randomized
// run against a behavioural model. Follows INT_SYNC_EN for interrupt latency.
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid_i;
   logic [4:0]  mem_exc_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_delayslot_i;
   logic        mem_cp0_we_i;
   logic [4:0]  mem_cp0_waddr_i;
   logic [31:0] mem_cp0_wdata_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic [5:0]  int_i, int_o;
   logic [31:0] excepttype_o, exc_pc_o, redirect_pc_o;
   logic        exc_in_delayslot_o, flush_o, redirect_valid_o, redirect_ready_i, stall_o;

   int n_checks = 0;
   int n_fail   = 0;

   exception_ctrl dut (
      .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid_i), .mem_exc_i(mem_exc_i),
      .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
      .mem_cp0_we_i(mem_cp0_we_i), .mem_cp0_waddr_i(mem_cp0_waddr_i),
      .mem_cp0_wdata_i(mem_cp0_wdata_i), .cp0_status_i(cp0_status_i),
      .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .int_i(int_i), .int_o(int_o),
      .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o),
      .exc_in_delayslot_o(exc_in_delayslot_o), .flush_o(flush_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .redirect_ready_i(redirect_ready_i), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

`ifdef INT_SYNC_EN
   localparam int INT_LAT = 2;
`else
   localparam int INT_LAT = 0;
`endif

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_fwd(logic [31:0] cur, logic we, logic [4:0] wa,
                                           logic [31:0] wd, logic [4:0] addr,
                                           logic [31:0] mask);
      if (we && wa == addr) return (cur & ~mask) | (wd & mask);
      return cur;
   endfunction

   function automatic logic [31:0] ref_code(logic valid, logic [4:0] f,
                                            logic [31:0] st, logic [31:0] ca);
      int ip;
      if (!valid) return 32'h0;
      ip = int'((st >> 8) & (ca >> 8) & 32'hff);
      if (st[0] == 1'b1 && st[1] == 1'b0 && ip != 0) return 32'h01;
      if (f[0]) return 32'h0a;
      if (f[1]) return 32'h0c;
      if (f[2]) return 32'h0d;
      if (f[3]) return 32'h08;
      if (f[4]) return 32'h0e;
      return 32'h0;
   endfunction

   function automatic logic [31:0] ref_status();
      return ref_fwd(cp0_status_i, mem_cp0_we_i, mem_cp0_waddr_i, mem_cp0_wdata_i, 5'd12, 32'hffff_ffff);
   endfunction
   function automatic logic [31:0] ref_cause();
      return ref_fwd(cp0_cause_i, mem_cp0_we_i, mem_cp0_waddr_i, mem_cp0_wdata_i, 5'd13, 32'h00c0_0300);
   endfunction
   function automatic logic [31:0] ref_epc();
      return ref_fwd(cp0_epc_i, mem_cp0_we_i, mem_cp0_waddr_i, mem_cp0_wdata_i, 5'd14, 32'hffff_ffff);
   endfunction

   task automatic clear_inputs();
      mem_valid_i = 1'b0; mem_exc_i = 5'h0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0;
      mem_cp0_we_i = 1'b0; mem_cp0_waddr_i = 5'h0; mem_cp0_wdata_i = 32'h0;
      cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
      int_i = 6'h0; redirect_ready_i = 1'b1;
   endtask

   // Advance to just after the next rising edge (input drive point)
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      mem_valid_i = 1'b1; mem_exc_i = 5'h1f; int_i = 6'h3f;
      repeat (2) next_cycle();
      #3;
      n_checks++; if (excepttype_o !== 32'h0) begin n_fail++; $display("FAIL reset_excepttype got=%h exp=0", excepttype_o); end
      n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
      n_checks++; if (redirect_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", redirect_valid_o); end
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
      n_checks++; if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc_o); end
      n_checks++; if (int_o !== ((INT_LAT == 0) ? 6'h3f : 6'h00)) begin n_fail++; $display("FAIL reset_int_o got=%h", int_o); end
      next_cycle();
      clear_inputs();
      rst_n = 1'b1;
      #3;
      $display("reset: released");
   endtask

   task automatic test_ri();
      next_cycle();
      mem_valid_i = 1'b1; mem_exc_i = 5'b00001; mem_pc_i = 32'h100;
      mem_in_delayslot_i = 1'b1; redirect_ready_i = 1'b1;
      #3;
      n_checks++; if (excepttype_o !== 32'h0a) begin n_fail++; $display("FAIL ri_code got=%h exp=0a", excepttype_o); end
      n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL ri_flush got=%b exp=1", flush_o); end
      n_checks++; if (exc_pc_o !== 32'h100) begin n_fail++; $display("FAIL ri_exc_pc got=%h exp=100", exc_pc_o); end
      n_checks++; if (exc_in_delayslot_o !== 1'b1) begin n_fail++; $display("FAIL ri_ds got=%b exp=1", exc_in_delayslot_o); end
      n_checks++; if (redirect_valid_o !== 1'b0) begin n_fail++; $display("FAIL ri_rvalid0 got=%b exp=0", redirect_valid_o); end
      next_cycle();
      clear_inputs();
      #3;
      n_checks++; if (redirect_valid_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL ri_redirect valid=%b stall=%b exp=1/1", redirect_valid_o, stall_o); end
      n_checks++; if (redirect_pc_o !== 32'h20) begin n_fail++; $display("FAIL ri_rpc got=%h exp=20", redirect_pc_o); end
      n_checks++; if (flush_o !== 1'b0 || excepttype_o !== 32'h0) begin n_fail++; $display("FAIL ri_quiet flush=%b code=%h exp=0/0", flush_o, excepttype_o); end
      next_cycle();
      #3;
      n_checks++; if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL ri_idle valid=%b stall=%b exp=0/0", redirect_valid_o, stall_o); end
      $display("ri: code=%h rpc=%h", 32'h0a, 32'h20);
   endtask

   task automatic test_eret_forward();
      next_cycle();
      mem_valid_i = 1'b1; mem_exc_i = 5'b10000; cp0_epc_i = 32'h400;
      mem_cp0_we_i = 1'b1; mem_cp0_waddr_i = 5'd14; mem_cp0_wdata_i = 32'h500;
      #3;
      n_checks++; if (excepttype_o !== 32'h0e) begin n_fail++; $display("FAIL eret_code got=%h exp=0e", excepttype_o); end
      next_cycle();
      clear_inputs();
      #3;
      n_checks++; if (redirect_pc_o !== 32'h500 || redirect_valid_o !== 1'b1) begin n_fail++; $display("FAIL eret_rpc got=%h valid=%b exp=500/1", redirect_pc_o, redirect_valid_o); end
      next_cycle();
      $display("eret: forwarded epc=%h", 32'h500);
   endtask

   typedef struct packed {
      logic [31:0] status;
      logic [31:0] cause;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  flags;
      logic [31:0] code;
   } prio_case_t;

   task automatic test_priority();
      prio_case_t tbl [9];
      logic [31:0] exp_pc;
      tbl = '{
         '{32'h401, 32'h400, 1'b0, 5'd0,  32'h0,   5'b00010, 32'h01},
         '{32'h400, 32'h400, 1'b0, 5'd0,  32'h0,   5'b00010, 32'h0c},
         '{32'h403, 32'h400, 1'b0, 5'd0,  32'h0,   5'b00010, 32'h0c},
         '{32'h101, 32'h000, 1'b1, 5'd13, 32'h100, 5'b00001, 32'h01},
         '{32'h401, 32'h000, 1'b1, 5'd13, 32'h400, 5'b00001, 32'h0a},
         '{32'h000, 32'h400, 1'b1, 5'd12, 32'h401, 5'b00100, 32'h01},
         '{32'h000, 32'h000, 1'b0, 5'd0,  32'h0,   5'b11100, 32'h0d},
         '{32'h000, 32'h000, 1'b0, 5'd0,  32'h0,   5'b11000, 32'h08},
         '{32'h000, 32'h000, 1'b0, 5'd0,  32'h0,   5'b10000, 32'h0e}
      };
      foreach (tbl[i]) begin
         next_cycle();
         clear_inputs();
         mem_valid_i = 1'b1; cp0_epc_i = 32'h1234;
         cp0_status_i = tbl[i].status; cp0_cause_i = tbl[i].cause;
         mem_cp0_we_i = tbl[i].we; mem_cp0_waddr_i = tbl[i].waddr; mem_cp0_wdata_i = tbl[i].wdata;
         mem_exc_i = tbl[i].flags;
         #3;
         n_checks++; if (excepttype_o !== tbl[i].code) begin n_fail++; $display("FAIL prio_%0d_code got=%h exp=%h", i, excepttype_o, tbl[i].code); end
         exp_pc = (tbl[i].code == 32'h0e) ? 32'h1234 : 32'h20;
         next_cycle();
         clear_inputs();
         #3;
         n_checks++; if (redirect_pc_o !== exp_pc) begin n_fail++; $display("FAIL prio_%0d_rpc got=%h exp=%h", i, redirect_pc_o, exp_pc); end
         $display("prio case %0d: code=%h", i, tbl[i].code);
      end
      next_cycle();
   endtask

   task automatic test_syscall_wait();
      next_cycle();
      mem_valid_i = 1'b1; mem_exc_i = 5'b01000; redirect_ready_i = 1'b0;
      #3;
      n_checks++; if (excepttype_o !== 32'h08) begin n_fail++; $display("FAIL sys_code got=%h exp=08", excepttype_o); end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mem_exc_i = 5'b00100;
         redirect_ready_i = (i == 3);
         #3;
         n_checks++; if (redirect_valid_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL sys_wait_%0d valid=%b stall=%b exp=1/1", i, redirect_valid_o, stall_o); end
         n_checks++; if (redirect_pc_o !== 32'h20) begin n_fail++; $display("FAIL sys_rpc_%0d got=%h exp=20", i, redirect_pc_o); end
         n_checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL sys_trap_ignored_%0d code=%h flush=%b exp=0/0", i, excepttype_o, flush_o); end
      end
      next_cycle();
      clear_inputs();
      #3;
      n_checks++; if (redirect_valid_o !== 1'b0 || excepttype_o !== 32'h0) begin n_fail++; $display("FAIL sys_done valid=%b code=%h exp=0/0", redirect_valid_o, excepttype_o); end
      $display("syscall: held 4 cycles");
   endtask

   task automatic test_mem_invalid();
      next_cycle();
      mem_valid_i = 1'b0; mem_exc_i = 5'h1f; cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
      #3;
      n_checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL invalid_code code=%h flush=%b exp=0/0", excepttype_o, flush_o); end
      next_cycle();
      #3;
      n_checks++; if (redirect_valid_o !== 1'b0) begin n_fail++; $display("FAIL invalid_rvalid got=%b exp=0", redirect_valid_o); end
      clear_inputs();
      $display("bubble: no exception");
   endtask

   task automatic test_reset_mid();
      next_cycle();
      mem_valid_i = 1'b1; mem_exc_i = 5'b01000; redirect_ready_i = 1'b0;
      next_cycle();
      mem_exc_i = 5'h0;
      #3;
      n_checks++; if (redirect_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1", redirect_valid_o); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0 || redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_async valid=%b stall=%b rpc=%h exp=0/0/0", redirect_valid_o, stall_o, redirect_pc_o); end
      n_checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_code code=%h flush=%b exp=0/0", excepttype_o, flush_o); end
      next_cycle();
      clear_inputs();
      rst_n = 1'b1;
      redirect_ready_i = 1'b0;
      next_cycle();
      #3;
      n_checks++; if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle valid=%b stall=%b exp=0/0", redirect_valid_o, stall_o); end
      clear_inputs();
      $display("reset mid-redirect: aborted");
   endtask

   task automatic test_int();
      next_cycle();
      int_i = 6'h0;
      repeat (3) next_cycle();
      int_i = 6'h01;
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) next_cycle();
         #1;
         n_checks++;
         if (int_o[0] !== ((k >= INT_LAT) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL int_edge_%0d got=%b exp=%b", k, int_o[0], (k >= INT_LAT));
         end
      end
      $display("int: latency %0d edges", INT_LAT);
      int_i = 6'h0;
   endtask

   task automatic test_random();
      bit          busy = 0;
      logic [31:0] rpc  = 32'h0;
      logic [31:0] code;
      for (int c = 0; c < 400; c++) begin
         next_cycle();
         mem_valid_i        = ($urandom_range(0, 7) != 0);
         mem_exc_i          = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
         mem_pc_i           = $urandom;
         mem_in_delayslot_i = 1'($urandom);
         cp0_status_i       = $urandom & 32'h0000_ff03;
         cp0_cause_i        = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h00c0_ff00) : 32'h0;
         cp0_epc_i          = $urandom;
         mem_cp0_we_i       = 1'($urandom);
         mem_cp0_waddr_i    = 5'($urandom_range(11, 15));
         mem_cp0_wdata_i    = $urandom;
         redirect_ready_i   = ($urandom_range(0, 2) != 0);
         int_i              = 6'($urandom);
         code = busy ? 32'h0 : ref_code(mem_valid_i, mem_exc_i, ref_status(), ref_cause());
         #3;
         n_checks++;
         if (excepttype_o !== code || flush_o !== (code != 0) || redirect_valid_o !== busy ||
             stall_o !== busy || (busy && redirect_pc_o !== rpc) || exc_pc_o !== mem_pc_i ||
             exc_in_delayslot_o !== mem_in_delayslot_i) begin
            n_fail++;
            $display("FAIL rand_%0d code=%h/%h flush=%b valid=%b/%b rpc=%h/%h", c, excepttype_o, code,
                     flush_o, redirect_valid_o, busy, redirect_pc_o, rpc);
         end
         if (busy) begin
            if (redirect_ready_i) busy = 0;
         end else if (code != 0) begin
            busy = 1;
            rpc  = (code == 32'h0e) ? ref_epc() : 32'h20;
         end
      end
      next_cycle();
      clear_inputs();
      repeat (2) next_cycle();
      $display("random: 400 cycles");
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_ri();
      test_eret_forward();
      test_priority();
      test_syscall_wait();
      test_mem_invalid();
      test_reset_mid();
      test_int();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout exceeded sim time limit");
      $fatal(1, "timeout");
   end

endmodule
